// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data memory controller.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Request payload held while the access is in flight (address kept separately, it is parameterised)
  typedef struct packed {
    logic              we;
    size_e             size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // True when a legal size is not naturally aligned at the given byte offset
  function automatic logic misaligned(input size_e size, input logic [1:0] addr);
    case (size)
      SZ_HALF: misaligned = addr[0];
      SZ_WORD: misaligned = (addr != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store mask/replication and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e             size,
  input  logic              sgn,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [LANES-1:0]  be_c,
  output logic [DATA_W-1:0] wword_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Little-endian lane selection, store data replicated across lanes
  always_comb begin
    be_c    = '0;
    wword_c = wdata;
    rdata_c = '0;
    lane_b  = rword[{addr, 3'b000} +: 8];
    lane_h  = addr[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr;
        wword_c = {4{wdata[7:0]}};
        rdata_c = {{24{sgn & lane_b[7]}}, lane_b};
      end
      SZ_HALF: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wword_c = {2{wdata[15:0]}};
        rdata_c = {{16{sgn & lane_h[15]}}, lane_h};
      end
      SZ_WORD: begin
        be_c    = 4'b1111;
        wword_c = wdata;
        rdata_c = rword;
      end
      default: begin
        be_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle byte/half/word data memory with valid/ready handshake and self-clearing init.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned WIX_W = ADDR_W - 2;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [IDX_W-1:0]  init_cnt_q;
  logic [LAT_W-1:0]  wait_cnt_q;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;

  req_t              req_in_c;
  req_t              acc_req_c;
  logic [ADDR_W-1:0] acc_addr_c;
  logic [IDX_W-1:0]  acc_idx_c;
  logic              acc_err_c;
  logic              access_c;
  logic [LANES-1:0]  be_c;
  logic [DATA_W-1:0] wword_c;
  logic [DATA_W-1:0] ld_data_c;

  // Access operands: live inputs when the access happens on the acceptance edge, latched otherwise
  always_comb begin
    req_in_c   = '{we: req_we, size: size_e'(req_size), sgn: req_signed, wdata: req_wdata};
    acc_req_c  = (LATENCY == 1) ? req_in_c : req_q;
    acc_addr_c = (LATENCY == 1) ? req_addr : addr_q;
    acc_idx_c  = acc_addr_c[IDX_W+1:2];
    acc_err_c  = (acc_req_c.size == SZ_ILL) ||
                 misaligned(acc_req_c.size, acc_addr_c[1:0]) ||
                 (acc_addr_c[ADDR_W-1:2] >= WIX_W'(DEPTH));
    access_c   = ((state_q == ST_WAIT) && (wait_cnt_q == '0)) ||
                 ((LATENCY == 1) && (state_q == ST_IDLE) && req_valid && req_ready);
  end

  dmem_lane_align u_align (
    .size    (acc_req_c.size),
    .sgn     (acc_req_c.sgn),
    .addr    (acc_addr_c[1:0]),
    .wdata   (acc_req_c.wdata),
    .rword   (mem[acc_idx_c]),
    .be_c    (be_c),
    .wword_c (wword_c),
    .rdata_c (ld_data_c)
  );

  // Storage: zero-fill sweep during INIT, lane-masked commit of legal stores at the access point
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_INIT) begin
        mem[init_cnt_q] <= '0;
      end else if (access_c && acc_req_c.we && !acc_err_c) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (be_c[i]) mem[acc_idx_c][8*i +: 8] <= wword_c[8*i +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      req_q      <= '0;
      addr_q     <= '0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (access_c) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err_c;
        rsp_rdata <= (acc_req_c.we || acc_err_c) ? '0 : ld_data_c;
      end
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == IDX_W'(DEPTH - 1)) begin
            state_q   <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_q      <= req_in_c;
            addr_q     <= req_addr;
            wait_cnt_q <= LAT_W'(LATENCY - 1);
            req_ready  <= 1'b0;
            state_q    <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) state_q <= ST_RESP;
          else                  wait_cnt_q <= wait_cnt_q - 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q   <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule
